// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer and its instruction decoder.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_JNZ  = 3'd3,
    OP_JREL = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/pc_seq_call_stack.sv
// LIFO return-address stack; push is ignored when full, pop when empty.
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Entry storage carries no reset; slots at or above cnt are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst && push && !full && (CNT_W'(i) == cnt)) mem[i] <= din;
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == cnt) dout = mem[i];
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: PC register, next-PC mux, RUN/HALT FSM and sticky stack flags.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic                             z_flag,
  output logic [ADDR_WIDTH-1:0]            pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stk_cnt,
  output logic                             stk_ovf,
  output logic                             stk_unf,
  output logic                             halted
);

  state_e                state;
  op_e                   op_d;
  logic                  run;
  logic                  stk_push;
  logic                  stk_pop;
  logic                  stk_full;
  logic                  stk_empty;
  logic [ADDR_WIDTH-1:0] stk_top;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_nxt;

  assign op_d     = op_e'(op);
  assign run      = rst && (state == ST_RUN) && !stall;
  assign stk_push = run && (op_d == OP_CALL) && !stk_full;
  assign stk_pop  = run && (op_d == OP_RET) && !stk_empty;
  assign pc_inc   = pc_out + 1'b1;

  call_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .cnt   (stk_cnt),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // JREL adds the offset at full width, so two's-complement wrap gives the sign extension.
  always_comb begin
    pc_nxt = pc_inc;
    case (op_d)
      OP_NEXT: pc_nxt = pc_inc;
      OP_JMP:  pc_nxt = target;
      OP_JZ:   pc_nxt = z_flag ? target : pc_inc;
      OP_JNZ:  pc_nxt = z_flag ? pc_inc : target;
      OP_JREL: pc_nxt = pc_out + target;
      OP_CALL: pc_nxt = stk_full ? pc_inc : target;
      OP_RET:  pc_nxt = stk_empty ? pc_inc : stk_top;
      OP_HALT: pc_nxt = pc_out;
      default: pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_RUN;
      pc_out  <= ADDR_WIDTH'(RESET_ADDR);
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      halted  <= 1'b0;
    end else if (state == ST_RUN && !stall) begin
      pc_out <= pc_nxt;
      if (op_d == OP_CALL && stk_full)  stk_ovf <= 1'b1;
      if (op_d == OP_RET  && stk_empty) stk_unf <= 1'b1;
      if (op_d == OP_HALT) begin
        state  <= ST_HALT;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus random ops against a queue-based model.
module tb_pc_seq;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] target = '0;
  logic          z_flag = 1'b0;
  logic [AW-1:0] pc_out;
  logic [2:0]    stk_cnt;
  logic          stk_ovf;
  logic          stk_unf;
  logic          halted;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  int unsigned m_pc;
  int unsigned m_stk[$];
  bit          m_ovf, m_unf, m_halt;

  pc_seq #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .op      (op),
    .target  (target),
    .z_flag  (z_flag),
    .pc_out  (pc_out),
    .stk_cnt (stk_cnt),
    .stk_ovf (stk_ovf),
    .stk_unf (stk_unf),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input int o, input int t, input bit z);
    int off;
    if (!r) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
    end else if (!m_halt && !s) begin
      case (o)
        0: m_pc = (m_pc + 1) % 256;
        1: m_pc = t;
        2: m_pc = z ? t : (m_pc + 1) % 256;
        3: m_pc = z ? (m_pc + 1) % 256 : t;
        4: begin
          off  = (t >= 128) ? t - 256 : t;
          m_pc = (m_pc + off + 256) % 256;
        end
        5: if (m_stk.size() < DEPTH) begin
             m_stk.push_back((m_pc + 1) % 256);
             m_pc = t;
           end else begin
             m_ovf = 1;
             m_pc  = (m_pc + 1) % 256;
           end
        6: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
           else begin
             m_unf = 1;
             m_pc  = (m_pc + 1) % 256;
           end
        default: m_halt = 1;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit s, input int o, input int t, input bit z);
    @(negedge clk);
    rst = r; stall = s; op = 3'(o); target = AW'(t); z_flag = z;
    @(posedge clk);
    model_step(r, s, o, t, z);
    #1;
    chk("pc_out",  32'(pc_out),  m_pc);
    chk("stk_cnt", 32'(stk_cnt), m_stk.size());
    chk("stk_ovf", 32'(stk_ovf), 32'(m_ovf));
    chk("stk_unf", 32'(stk_unf), 32'(m_unf));
    chk("halted",  32'(halted),  32'(m_halt));
  endtask

  task automatic run_op(input int o, input int t, input bit z = 1'b0);
    step(1'b1, 1'b0, o, t, z);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    // Reset state, then incrementing and wrap
    do_reset();
    chk("reset_pc", 32'(pc_out), 32'h00);
    for (int i = 1; i <= 3; i++) begin
      run_op(0, 0);
      chk("next_pc", 32'(pc_out), 32'(i));
    end
    run_op(1, 8'hFF);
    run_op(0, 0);
    chk("next_wrap", 32'(pc_out), 32'h00);

    // Relative and conditional jumps
    run_op(1, 8'h10);
    run_op(4, 8'hFE);
    chk("jrel_back", 32'(pc_out), 32'h0E);
    run_op(2, 8'h40, 1'b0);
    chk("jz_nottaken", 32'(pc_out), 32'h0F);
    run_op(2, 8'h40, 1'b1);
    chk("jz_taken", 32'(pc_out), 32'h40);
    run_op(3, 8'h70, 1'b1);
    chk("jnz_nottaken", 32'(pc_out), 32'h41);
    run_op(3, 8'h70, 1'b0);
    chk("jnz_taken", 32'(pc_out), 32'h70);

    // Nested calls, overflow, returns, underflow
    do_reset();
    run_op(1, 8'h01); run_op(5, 8'h20);
    run_op(1, 8'h21); run_op(5, 8'h30);
    run_op(1, 8'h31); run_op(5, 8'h40);
    run_op(1, 8'h41); run_op(5, 8'h50);
    chk("call_cnt4", 32'(stk_cnt), 32'd4);
    chk("call_pc", 32'(pc_out), 32'h50);
    run_op(5, 8'h99);
    chk("ovf_pc", 32'(pc_out), 32'h51);
    chk("ovf_flag", 32'(stk_ovf), 32'd1);
    chk("ovf_cnt", 32'(stk_cnt), 32'd4);
    run_op(6, 0); chk("ret1", 32'(pc_out), 32'h42);
    run_op(6, 0); chk("ret2", 32'(pc_out), 32'h32);
    run_op(6, 0); chk("ret3", 32'(pc_out), 32'h22);
    run_op(6, 0); chk("ret4", 32'(pc_out), 32'h02);
    chk("ret_cnt0", 32'(stk_cnt), 32'd0);
    run_op(6, 0);
    chk("unf_pc", 32'(pc_out), 32'h03);
    chk("unf_flag", 32'(stk_unf), 32'd1);
    run_op(0, 0);
    chk("ovf_sticky", 32'(stk_ovf), 32'd1);

    // Stall, halt and recovery by reset
    do_reset();
    run_op(1, 8'h33);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1, 8'h80, 1'b0);
      chk("stall_pc", 32'(pc_out), 32'h33);
    end
    run_op(7, 0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc_out), 32'h33);
    run_op(0, 0);
    run_op(1, 8'h80);
    chk("halt_frozen", 32'(pc_out), 32'h33);
    do_reset();
    chk("halt_rst_pc", 32'(pc_out), 32'h00);
    chk("halt_rst_flag", 32'(halted), 32'd0);

    // Randomized traffic including stalls and occasional resets
    for (int i = 0; i < 600; i++) begin
      bit r, s, z;
      int o, t;
      r = ($urandom_range(0, 99) >= 4);
      s = ($urandom_range(0, 3) == 0);
      z = 1'($urandom_range(0, 1));
      o = $urandom_range(0, 15);
      if (o > 7) o = o % 2 == 0 ? 5 : 6;
      if (o == 7 && $urandom_range(0, 3) != 0) o = 0;
      t = $urandom_range(0, 255);
      step(r, s, o, t, z);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
